// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: start/stream/memory-write/status bundle for the program loader.
// The host side (byte source and CPU control) uses the master modport and the loader uses slave.
`default_nettype none

interface instr_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

`default_nettype wire

// File: rtl/instr_mem_loader.sv
//==============================================================================
// Module  : instr_mem_loader
// Brief   : Length-prefixed byte-stream loader writing instruction memory one
//           byte per cycle from BASE_ADDR; optional trailing XOR checksum
//           enabled by defining LOADER_CHECKSUM_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module instr_mem_loader #(
  parameter int DEPTH     = 100,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  wire                  clk,
  input  wire                  rst_n,
  instr_mem_loader_if.slave    bus
);

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       c_depth     = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_s_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [15:0]       r_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              w_xfer;
  logic [15:0]       w_len;
  logic              w_oversize;
  logic              w_last;

  assign w_xfer     = bus.s_valid && r_s_ready;
  assign w_len      = {r_len_hi, bus.s_data};
  assign w_oversize = ({1'b0, w_len} > c_depth);
  assign w_last     = (r_idx == (r_len - 16'd1));

  // s_ready is registered alongside the state so it is a pure function of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s_ready  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_idx      <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse belongs to the finished load.
          if (bus.start && !r_done) begin
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_s_ready  <= 1'b1;
            r_idx      <= '0;
            r_state    <= S_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= bus.s_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
              r_s_ready <= 1'b0;
              r_state   <= S_FIN;
            end else if (w_oversize) begin
              r_s_ready <= 1'b0;
              r_err     <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= c_base_addr + ADDR_W'(r_idx);
            r_wr_data <= bus.s_data;
            r_idx     <= r_idx + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            r_xor     <= r_xor ^ bus.s_data;
            if (w_last) begin
              r_state <= S_CHK;
            end
`else
            if (w_last) begin
              r_s_ready <= 1'b0;
              r_state   <= S_FIN;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_s_ready <= 1'b0;
            if (bus.s_data == r_xor) begin
              r_state <= S_FIN;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
`endif
        S_FIN: begin
          // The final write is visible during this cycle; completion follows it.
          r_done     <= 1'b1;
          r_cpu_hold <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_s_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready  = r_s_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.cpu_hold = r_cpu_hold;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

`default_nettype wire
